// File: rtl/alu_issue_pkg.sv
// Shared decode definitions for the ALU issue unit: opcodes, FSM states, field positions.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package alu_issue_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_NOT  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SRA  = 4'd4,
    OP_SLL  = 4'd5,
    OP_BEQZ = 4'd6,
    OP_BNEZ = 4'd7,
    OP_XOR  = 4'd8,
    OP_LI   = 4'd9
  } op_e;

  // Select code that keeps the ALU idle; also used for LI and illegal opcodes.
  localparam logic [3:0] ALU_NOP = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  // Instruction field bit positions.
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 8;
  localparam int IMM_LSB = 0;

  function automatic logic [15:0] sext9(input logic [8:0] v);
    return {{7{v[8]}}, v};
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_BEQZ) || (op == OP_BNEZ);
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op > OP_LI;
  endfunction

  function automatic logic [3:0] alu_sel(input logic [3:0] op);
    return (op <= OP_XOR) ? op : ALU_NOP;
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Instruction handshake plus ALU operand/result bus between fetch, issue unit and ALU.
// Latency: n/a (wires only).
// Backpressure: instr_valid/instr_ready; ALU side is purely combinational.
// Ports: instr_valid/instr/instr_ready (fetch), alu_a/alu_b/alu_s (to ALU),
//        alu_f/alu_ovf/alu_take_branch (from ALU).
// slave = issue unit view, master = fetch/ALU view.
interface alu_issue_unit_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_s;
  logic [15:0] alu_f;
  logic        alu_ovf;
  logic        alu_take_branch;

  modport master (
    output instr_valid, instr, alu_f, alu_ovf, alu_take_branch,
    input  instr_ready, alu_a, alu_b, alu_s
  );

  modport slave (
    input  instr_valid, instr, alu_f, alu_ovf, alu_take_branch,
    output instr_ready, alu_a, alu_b, alu_s
  );
endinterface

// File: rtl/alu_issue_unit_regfile8x16.sv
// 8x16 register file: two async read ports, one async debug read port, one sync write port.
// Latency: reads combinational; write visible after the clock edge.
// Backpressure: none; writes to r0 are dropped and r0 always reads 0.
// Ports: clk, reset (async, active-high, clears all entries), ra1/rd1, ra2/rd2,
//        rdbg/rdbg_data, we/wa/wd.
module regfile8x16 #(
  parameter int NREGS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  ra1,
  input  logic [2:0]  ra2,
  input  logic [2:0]  rdbg,
  output logic [15:0] rd1,
  output logic [15:0] rd2,
  output logic [15:0] rdbg_data,
  input  logic        we,
  input  logic [2:0]  wa,
  input  logic [15:0] wd
);

  logic [15:0] mem [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (wa != 3'd0)) begin
      mem[wa] <= wd;
    end
  end

  assign rd1       = (ra1 == 3'd0)  ? 16'h0000 : mem[ra1];
  assign rd2       = (ra2 == 3'd0)  ? 16'h0000 : mem[ra2];
  assign rdbg_data = (rdbg == 3'd0) ? 16'h0000 : mem[rdbg];

endmodule

// File: rtl/alu_issue_unit.sv
// Issue/control engine for the 16-bit ALU: decode, operand fetch, result writeback, PC.
// Latency: accept at edge k, results/pc visible after k+2 (k+1 with ALU_ISSUE_FAST_WB_EN).
// Backpressure: instr_ready high only in IDLE; one instruction per 3 cycles (2 when fast).
// Ports: clk, reset (async, active-high), bus (alu_issue_unit_if.slave), pc, wb_valid,
//        illegal, ovf_flag, ovf_clr, dbg_addr, dbg_data.
// Optional: define ALU_ISSUE_FAST_WB_EN to retire straight out of EXEC on live ALU outputs.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter logic [15:0] RST_PC = 16'h0000,
  parameter int          NREGS  = 8
) (
  input  logic            clk,
  input  logic            reset,
  alu_issue_unit_if.slave bus,
  output logic [15:0]     pc,
  output logic            wb_valid,
  output logic            illegal,
  output logic            ovf_flag,
  input  logic            ovf_clr,
  input  logic [2:0]      dbg_addr,
  output logic [15:0]     dbg_data
);

  state_e      state, next_state;
  logic        accept, retire;
  logic [3:0]  op_in;
  logic [2:0]  rs_a;
  logic [3:0]  op_q;
  logic [2:0]  rd_q;
  logic [8:0]  imm_q;
  logic [15:0] rf_a, rf_b;
  logic [15:0] res_f;
  logic        res_ovf, res_tb;
  logic        rf_we;
  logic [15:0] rf_wd;

  assign op_in = bus.instr[OP_MSB:OP_LSB];
  // Branches carry their test register in the rd slot.
  assign rs_a  = is_branch(op_in) ? bus.instr[RD_MSB:RD_LSB] : bus.instr[RS1_MSB:RS1_LSB];

  regfile8x16 #(.NREGS(NREGS)) u_rf (
    .clk       (clk),
    .reset     (reset),
    .ra1       (rs_a),
    .ra2       (bus.instr[RS2_MSB:RS2_LSB]),
    .rdbg      (dbg_addr),
    .rd1       (rf_a),
    .rd2       (rf_b),
    .rdbg_data (dbg_data),
    .we        (rf_we),
    .wa        (rd_q),
    .wd        (rf_wd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state      = state;
    bus.instr_ready = 1'b0;
    accept          = 1'b0;
    retire          = 1'b0;
    case (state)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) begin
          accept     = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
`ifdef ALU_ISSUE_FAST_WB_EN
        retire     = 1'b1;
        next_state = IDLE;
`else
        next_state = WB;
`endif
      end
      WB: begin
        retire     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Operands are loaded on the accept edge so they are stable for the whole EXEC
  // cycle; the previous instruction has always written back before the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_s <= ALU_NOP;
    end else if (accept) begin
      op_q      <= op_in;
      rd_q      <= bus.instr[RD_MSB:RD_LSB];
      imm_q     <= bus.instr[IMM_MSB:IMM_LSB];
      bus.alu_a <= rf_a;
      bus.alu_b <= is_branch(op_in) ? 16'h0000 : rf_b;
      bus.alu_s <= alu_sel(op_in);
    end else if (state == EXEC) begin
      bus.alu_s <= ALU_NOP;
    end
  end

`ifdef ALU_ISSUE_FAST_WB_EN
  assign res_f   = bus.alu_f;
  assign res_ovf = bus.alu_ovf;
  assign res_tb  = bus.alu_take_branch;
`else
  logic [15:0] f_q;
  logic        ovf_q, tb_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_q   <= '0;
      ovf_q <= 1'b0;
      tb_q  <= 1'b0;
    end else if (state == EXEC) begin
      f_q   <= bus.alu_f;
      ovf_q <= bus.alu_ovf;
      tb_q  <= bus.alu_take_branch;
    end
  end

  assign res_f   = f_q;
  assign res_ovf = ovf_q;
  assign res_tb  = tb_q;
`endif

  assign rf_we = retire && !is_branch(op_q) && !is_illegal(op_q);
  assign rf_wd = (op_q == OP_LI) ? sext9(imm_q) : res_f;

  // wb_valid/illegal are registered so the pulse lines up with the cycle in which
  // the new pc and register contents are already visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RST_PC;
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      wb_valid <= retire;
      illegal  <= retire && is_illegal(op_q);
      if (retire) begin
        pc <= (is_branch(op_q) && res_tb) ? pc + sext9(imm_q) : pc + 16'd1;
      end
      // A new overflow takes priority over a simultaneous clear.
      if (retire && res_ovf && (op_q == OP_ADD)) ovf_flag <= 1'b1;
      else if (ovf_clr)                          ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU and a scoreboard of expected retirements.
// Latency: checks accept-to-wb_valid timing and issue spacing.
// Backpressure: exercises held-high instr_valid and idle instr_valid low.
module tb_alu_issue_unit;
  import alu_issue_pkg::*;

`ifdef ALU_ISSUE_FAST_WB_EN
  localparam int PERIOD = 2;
`else
  localparam int PERIOD = 3;
`endif

  typedef struct packed {
    logic [15:0] f;
    logic        ovf;
    logic        tb;
  } alu_res_t;

  typedef struct packed {
    logic [15:0] pc;
    logic        ill;
    logic        ovf;
    logic [2:0]  rd;
    logic [15:0] val;
    logic [3:0]  sel;
    logic [15:0] a;
    logic [15:0] b;
    logic        chk_ab;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        wb_valid, illegal, ovf_flag, ovf_clr;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  always #5 clk = ~clk;

  alu_issue_unit_if bus();

  alu_issue_unit #(.RST_PC(16'h0000), .NREGS(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .pc       (pc),
    .wb_valid (wb_valid),
    .illegal  (illegal),
    .ovf_flag (ovf_flag),
    .ovf_clr  (ovf_clr),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  function automatic alu_res_t alu_ref(input logic [3:0] s, input logic [15:0] a, input logic [15:0] b);
    alu_res_t r;
    r = '0;
    case (s)
      4'd0: begin r.f = a + b; r.ovf = (a[15] == b[15]) && (r.f[15] != a[15]); end
      4'd1: r.f = ~b;
      4'd2: r.f = a & b;
      4'd3: r.f = a | b;
      4'd4: r.f = $signed(a) >>> b[3:0];
      4'd5: r.f = a << b[3:0];
      4'd6: r.tb = (a == 16'h0000);
      4'd7: r.tb = (a != 16'h0000);
      4'd8: r.f = a ^ b;
      default: ;
    endcase
    return r;
  endfunction

  alu_res_t alu_now;
  assign alu_now             = alu_ref(bus.alu_s, bus.alu_a, bus.alu_b);
  assign bus.alu_f           = alu_now.f;
  assign bus.alu_ovf         = alu_now.ovf;
  assign bus.alu_take_branch = alu_now.tb;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_err = 0;
  int          last_wb_cyc = 0;
  logic [15:0] m_rf [8];
  logic [15:0] m_pc;
  logic        m_ovf;
  exp_t        sb_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
    m_pc  = 16'h0000;
    m_ovf = 1'b0;
  endtask

  task automatic model_exec(input logic [15:0] w, input logic clr, output exp_t e);
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic [15:0] off, a, b;
    logic        br, ill;
    alu_res_t    r;
    op  = w[15:12];
    rd  = w[11:9];
    rs1 = w[8:6];
    rs2 = w[5:3];
    off = {{7{w[8]}}, w[8:0]};
    br  = (op == 4'd6) || (op == 4'd7);
    ill = (op >= 4'd10);
    a   = br ? m_rf[rd] : m_rf[rs1];
    b   = br ? 16'h0000 : m_rf[rs2];
    e.sel    = (op <= 4'd8) ? op : 4'hF;
    e.a      = a;
    e.b      = b;
    e.chk_ab = (op <= 4'd8);
    r = alu_ref(e.sel, a, b);
    if (br && r.tb) m_pc = m_pc + off;
    else            m_pc = m_pc + 16'd1;
    if (!br && !ill && rd != 3'd0) m_rf[rd] = (op == 4'd9) ? off : r.f;
    if (op == 4'd0 && r.ovf) m_ovf = 1'b1;
    else if (clr)            m_ovf = 1'b0;
    e.pc  = m_pc;
    e.ill = ill;
    e.ovf = m_ovf;
    e.rd  = rd;
    e.val = m_rf[rd];
  endtask

  // Called at a negedge with the unit idle; returns at the negedge that shows wb_valid.
  task automatic issue(input logic [15:0] w, input logic clr);
    exp_t e, got;
    int   n;
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    n = 0;
    while (bus.instr_ready !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", (n < 8), 1);
    model_exec(w, clr, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    ovf_clr         = clr;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("alu_s_exec", bus.alu_s, e.sel);
        if (e.chk_ab) begin
          chk("alu_a_exec", bus.alu_a, e.a);
          chk("alu_b_exec", bus.alu_b, e.b);
        end
      end
    end while (wb_valid !== 1'b1 && n < 8);
    ovf_clr     = 1'b0;
    last_wb_cyc = cyc;
    chk("wb_latency", n, PERIOD);
    chk("sb_nonempty", (sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      chk("pc", pc, got.pc);
      chk("illegal", illegal, got.ill);
      chk("ovf_flag", ovf_flag, got.ovf);
      chk("alu_s_idle", bus.alu_s, 4'hF);
      dbg_addr = got.rd;
      #1;
      chk("rd_value", dbg_data, got.val);
    end
  endtask

  task automatic check_regs();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      chk("regfile", dbg_data, m_rf[i]);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, acc, bad;
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    ovf_clr         = 1'b0;
    dbg_addr        = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_ovf_flag", ovf_flag, 0);
    chk("rst_alu_s", bus.alu_s, 4'hF);
    chk("rst_alu_a", bus.alu_a, 16'h0000);
    chk("rst_alu_b", bus.alu_b, 16'h0000);

    // Load immediates and check retirement spacing.
    issue(16'h9205, 1'b0);            // LI r1,5
    c1 = last_wb_cyc;
    issue(16'h95FD, 1'b0);            // LI r2,-3
    chk("wb_spacing", last_wb_cyc - c1, PERIOD);
    check_regs();

    // r0 write discard and illegal opcode.
    issue(16'h9009, 1'b0);            // LI r0,9
    issue(16'hF000, 1'b0);            // illegal
    check_regs();

    // Branches on r0.
    issue(16'h61FE, 1'b0);            // BEQZ r0,-2 at pc=4 -> 2
    issue(16'h7007, 1'b0);            // BNEZ r0,+7 -> not taken

    // Build r1=0x7FFF and overflow.
    issue(16'h927F, 1'b0);            // LI r1,127
    issue(16'h9408, 1'b0);            // LI r2,8
    issue(16'h5250, 1'b0);            // SLL r1,r1,r2
    issue(16'h96FF, 1'b0);            // LI r3,255
    issue(16'h3258, 1'b0);            // OR r1,r1,r3
    issue(16'h0648, 1'b0);            // ADD r3,r1,r1 -> 0xFFFE, ovf
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    m_ovf   = 1'b0;
    chk("ovf_cleared", ovf_flag, 0);
    issue(16'h0848, 1'b1);            // ADD r4,r1,r1 with clear held: set wins
    issue(16'h8A58, 1'b0);            // XOR r5,r1,r3
    issue(16'h1C08, 1'b0);            // NOT r6,r1
    issue(16'h4F90, 1'b0);            // SRA r7,r6,r2
    issue(16'h2BC8, 1'b0);            // AND r5,r7,r1
    issue(16'h7203, 1'b0);            // BNEZ r1,+3 taken
    check_regs();

    // instr_valid low in IDLE: nothing moves.
    bus.instr = 16'h9E01;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.instr_ready !== 1'b1 || wb_valid !== 1'b0) bad++;
    end
    chk("idle_hold", bad, 0);
    chk("idle_pc", pc, m_pc);
    check_regs();

    // instr_valid held high: one accept per PERIOD cycles.
    bus.instr       = 16'h9A07;       // LI r5,7
    bus.instr_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.instr_ready === 1'b1) acc++;
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("accept_count", acc, 12 / PERIOD);
    m_rf[5] = 16'h0007;
    m_pc    = m_pc + 16'(12 / PERIOD);
    chk("stream_pc", pc, m_pc);
    check_regs();

    // Reset while ADD r1,r1,r1 is in EXEC.
    bus.instr       = 16'h0248;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    chk("exec_before_rst", bus.alu_s, 4'h0);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", bus.instr_ready, 1);
    chk("mid_rst_pc", pc, 16'h0000);
    chk("mid_rst_alu_s", bus.alu_s, 4'hF);
    chk("mid_rst_alu_a", bus.alu_a, 16'h0000);
    chk("mid_rst_ovf", ovf_flag, 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wb_valid !== 1'b0) bad++;
    end
    chk("no_wb_after_rst", bad, 0);
    check_regs();

    // PC wrap in both directions.
    issue(16'h61FF, 1'b0);            // BEQZ r0,-1 from pc=0 -> 0xFFFF
    issue(16'h9201, 1'b0);            // LI r1,1 -> pc wraps to 0
    check_regs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Multi-cycle issue/control engine on the driving side of the 16-bit ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them into ALU select codes.
- Sources ALU operands from an internal 8x16 register file, captures f/ovf/take_branch and writes results back.
- Maintains the PC. Sits between the fetch path and the combinational ALU.

Parameters:
- RST_PC, 16'h0000, PC value loaded on reset.
- NREGS, 8, register count; fixed at 8 because of the 3-bit fields.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction word valid
- instr  in  16  instruction word
- instr_ready  out  1  unit can accept an instruction
- alu_a  out  16  ALU operand a
- alu_b  out  16  ALU operand b
- alu_s  out  4  ALU select code
- alu_f  in  16  ALU result
- alu_ovf  in  1  ALU signed overflow
- alu_take_branch  in  1  ALU branch condition
- pc  out  16  program counter
- wb_valid  out  1  one-cycle pulse on each retired instruction
- illegal  out  1  one-cycle pulse on retirement of an illegal opcode
- ovf_flag  out  1  sticky overflow flag
- ovf_clr  in  1  synchronous clear of ovf_flag
- dbg_addr  in  3  debug register read address
- dbg_data  out  16  combinational read of reg[dbg_addr]

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high.
- On reset, all of the following clear immediately, and any in-flight instruction is dropped with no writeback:
  - state=IDLE; instr_ready=1
  - pc=RST_PC; all registers=0
  - wb_valid=0, illegal=0, ovf_flag=0
  - alu_a=0, alu_b=0, alu_s=4'hF
- Instruction format, op=instr[15:12]:
  - R-type, op 0..5 and 8: rd=[11:9], rs1=[8:6], rs2=[5:3]; [2:0] ignored.
  - Op 1 uses rs2 only; alu_a is still driven from rs1.
  - Branch, op 6 (beqz) and op 7 (bnez): rs=[11:9] drives alu_a; alu_b=0; off=sext([8:0]).
  - LI, op 9: rd=[11:9], imm=sext([8:0]). No ALU use; alu_s=4'hF.
  - Ops 10..15 are illegal.
- ALU select: alu_s equals op for ops 0..8, and 4'hF otherwise.
- Register r0: reads return 0; writes are discarded.
- FSM states and transitions:
  - IDLE: instr_ready=1. On instr_valid&&instr_ready the instruction is latched and the state moves to EXEC. Nothing is latched without valid.
  - EXEC: instr_ready=0. alu_a, alu_b and alu_s are driven registered from the latched fields and register file. At the end of the cycle, alu_f, alu_ovf and alu_take_branch are captured. Next state is WB.
  - WB: instr_ready=0. Write rd (non-branch, non-illegal), update pc, pulse wb_valid, and pulse illegal if the op was illegal. Next state is IDLE.
- Latency and throughput: accept at edge k; register write and pc update visible after edge k+2; instr_ready high again after edge k+2. Throughput is 1 instruction per 3 cycles.
- PC update:
  - Taken branch: pc+off.
  - All other instructions, including illegal and not-taken branches: pc+1.
  - Arithmetic is modulo 2^16 (0xFFFF+1 wraps to 0).
- ovf_flag: set in WB when the captured ovf=1 and op=0. ovf_clr clears it. If set and clear occur in the same cycle, set wins.
- Operand timing: operands are read in EXEC, so a back-to-back dependency always sees the prior writeback. No hazards exist.
- Outside EXEC: alu_a and alu_b hold their previous values; alu_s=4'hF.

Optional Feature:
- Macro ALU_ISSUE_FAST_WB_EN.
- When defined: the WB state is removed. Writeback, pc update, wb_valid, illegal and ovf_flag actions occur at the end of EXEC using the live ALU outputs. Throughput is 1 per 2 cycles and results are visible after edge k+1.
- When undefined: the 3-state behaviour above applies.

Decomposition:
- Package alu_issue_pkg holds:
  - opcode enum (OP_ADD=0, OP_NOT, OP_AND, OP_OR, OP_SRA, OP_SLL, OP_BEQZ, OP_BNEZ, OP_XOR, OP_LI=9)
  - ALU_NOP=4'hF
  - state enum {IDLE, EXEC, WB}
  - field bit-position constants
- Sub-module regfile8x16: 2 async read ports plus a debug read port, 1 sync write port, r0 hardwired to 0, async reset to 0.

Test Plan:
- Load immediates: LI r1,5 (0x9205); LI r2,-3 (0x95FD) -> dbg r1=0x0005, r2=0xFFFD, pc=2, two wb_valid pulses spaced 3 cycles.
- Overflow on add: r1=0x7FFF (built via LI/SLL/OR), ADD r3,r1,r1 -> r3=0xFFFE, ovf_flag=1. Then assert ovf_clr together with a second overflowing ADD in WB -> ovf_flag stays 1.
- Branches: BEQZ r0,-2 at pc=4 -> pc=2. BNEZ r0,+7 -> pc+1. BEQZ r0,-1 from pc=0 -> pc=0xFFFF (wrap).
- Illegal and r0 writes: opcode 0xF000 -> illegal pulse, pc+1, no register change. LI r0,9 -> r0 reads 0.
- Handshake: instr_valid held high continuously -> exactly one accept per 3 cycles (2 with ALU_ISSUE_FAST_WB_EN); instr_valid low in IDLE -> no state change.
- Reset in EXEC after ADD r1,r1,r1 -> all registers 0, pc=RST_PC, no wb_valid pulse, instr_ready=1.
